// File: rtl/gesture_pkg.sv
// Shared constants for the gesture-recognition datapath.
//   DEFAULT_NUMBER_WIDTH : default sample/sum width
//   SAT_WRAP / SAT_CLAMP : overflow handling mode encodings
package gesture_pkg;

  localparam int unsigned DEFAULT_NUMBER_WIDTH = 16;

  localparam int unsigned SAT_WRAP  = 0;
  localparam int unsigned SAT_CLAMP = 1;

endpackage : gesture_pkg

// File: rtl/integrator_sat_adder.sv
// Combinational unsigned adder with carry-out and optional clamp to all ones.
//   a, b      : NUMBER_WIDTH-bit unsigned operands
//   sum       : wrapped sum, or all ones on carry when SATURATE selects clamp
//   carry_out : carry of the (NUMBER_WIDTH+1)-bit sum, independent of mode
module sat_adder
  import gesture_pkg::*;
#(
  parameter int unsigned NUMBER_WIDTH = DEFAULT_NUMBER_WIDTH,
  parameter int unsigned SATURATE     = SAT_WRAP
) (
  input  logic [NUMBER_WIDTH-1:0] a,
  input  logic [NUMBER_WIDTH-1:0] b,
  output logic [NUMBER_WIDTH-1:0] sum,
  output logic                    carry_out
);

  localparam int unsigned FULL_WIDTH = NUMBER_WIDTH + 1;
  localparam bit          CLAMP      = (SATURATE != SAT_WRAP);

  logic [FULL_WIDTH-1:0] full_sum;

  // Widen both operands so the carry lands in the top bit.
  always_comb begin
    full_sum  = FULL_WIDTH'(a) + FULL_WIDTH'(b);
    carry_out = full_sum[NUMBER_WIDTH];
    if (CLAMP && full_sum[NUMBER_WIDTH]) begin
      sum = '1;
    end else begin
      sum = full_sum[NUMBER_WIDTH-1:0];
    end
  end

endmodule : sat_adder

// File: rtl/integrator.sv
// Running-sum accumulator: adds each valid sample into a registered sum.
//   clk, rst_n   : clock, synchronous active-low reset
//   input_number : unsigned sample
//   input_valid  : qualifies input_number this cycle
//   clear        : restarts the window; a same-cycle sample seeds the new sum
//   output_sum   : registered accumulated sum
//   output_valid : high the cycle after an accepted sample
//   overflow     : sticky carry-out flag since last clear/reset
module integrator
  import gesture_pkg::*;
#(
  parameter int unsigned NUMBER_WIDTH = DEFAULT_NUMBER_WIDTH,
  parameter int unsigned SATURATE     = SAT_WRAP
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUMBER_WIDTH-1:0] input_number,
  input  logic                    input_valid,
  input  logic                    clear,
  output logic [NUMBER_WIDTH-1:0] output_sum,
  output logic                    output_valid,
  output logic                    overflow
);

  logic [NUMBER_WIDTH-1:0] add_sum;
  logic                    add_carry;

  sat_adder #(
    .NUMBER_WIDTH (NUMBER_WIDTH),
    .SATURATE     (SATURATE)
  ) u_sat_adder (
    .a         (output_sum),
    .b         (input_number),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // Priority: reset > clear > input_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_sum   <= '0;
      output_valid <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear) begin
      output_sum   <= input_valid ? input_number : '0;
      output_valid <= input_valid;
      overflow     <= 1'b0;
    end else if (input_valid) begin
      output_sum   <= add_sum;
      output_valid <= 1'b1;
      if (add_carry) begin
        overflow <= 1'b1;
      end
    end else begin
      output_valid <= 1'b0;
    end
  end

endmodule : integrator

// File: tb/tb_integrator.sv
// Self-checking bench for integrator: one wrapping and one saturating instance
// driven in lockstep by directed vectors with hand-computed expectations.
module tb_integrator;

  localparam int unsigned W = 16;

  typedef struct {
    string        name;
    logic [W-1:0] w_sum;
    logic         w_valid;
    logic         w_ovf;
    logic [W-1:0] s_sum;
    logic         s_valid;
    logic         s_ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] input_number;
  logic         input_valid;
  logic         clear;

  logic [W-1:0] w_sum, s_sum;
  logic         w_valid, s_valid, w_ovf, s_ovf;

  exp_t exp_q[$];
  int   applied   = 0;
  int   miscmp    = 0;

  always #5 clk = ~clk;

  integrator #(.NUMBER_WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_number (input_number),
    .input_valid  (input_valid),
    .clear        (clear),
    .output_sum   (w_sum),
    .output_valid (w_valid),
    .overflow     (w_ovf)
  );

  integrator #(.NUMBER_WIDTH(W), .SATURATE(1)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_number (input_number),
    .input_valid  (input_valid),
    .clear        (clear),
    .output_sum   (s_sum),
    .output_valid (s_valid),
    .overflow     (s_ovf)
  );

  // Drive one cycle of inputs and queue the expected outputs after the next edge.
  task automatic vec(input string name, input logic r, input logic c, input logic v,
                     input logic [W-1:0] n,
                     input logic [W-1:0] ws, input logic wv, input logic wo,
                     input logic [W-1:0] ss, input logic sv, input logic so);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n        = r;
    clear        = c;
    input_valid  = v;
    input_number = n;
    e.name = name;
    e.w_sum = ws; e.w_valid = wv; e.w_ovf = wo;
    e.s_sum = ss; e.s_valid = sv; e.s_ovf = so;
    exp_q.push_back(e);
  endtask

  // Monitor: shortly after each edge, compare both instances against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        applied++;
        if (w_sum !== e.w_sum || w_valid !== e.w_valid || w_ovf !== e.w_ovf) begin
          miscmp++;
          $display("FAIL %s wrap: got sum=%h valid=%b ovf=%b, want sum=%h valid=%b ovf=%b",
                   e.name, w_sum, w_valid, w_ovf, e.w_sum, e.w_valid, e.w_ovf);
        end
        if (s_sum !== e.s_sum || s_valid !== e.s_valid || s_ovf !== e.s_ovf) begin
          miscmp++;
          $display("FAIL %s sat: got sum=%h valid=%b ovf=%b, want sum=%h valid=%b ovf=%b",
                   e.name, s_sum, s_valid, s_ovf, e.s_sum, e.s_valid, e.s_ovf);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; input_valid = 1'b0; input_number = '0;

    // name           rst clr vld num       wrap: sum vld ovf      sat: sum vld ovf
    vec("reset0",     0,  0,  0,  16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("reset1",     0,  0,  0,  16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("idle0",      1,  0,  0,  16'h0001, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("idle1",      1,  0,  0,  16'h0001, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("const1",     1,  0,  1,  16'h0001, 16'h0001, 1, 0, 16'h0001, 1, 0);
    vec("const2",     1,  0,  1,  16'h0001, 16'h0002, 1, 0, 16'h0002, 1, 0);
    vec("const3",     1,  0,  1,  16'h0001, 16'h0003, 1, 0, 16'h0003, 1, 0);
    vec("clr_empty0", 1,  1,  0,  16'h0001, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("gap_a",      1,  0,  1,  16'h0005, 16'h0005, 1, 0, 16'h0005, 1, 0);
    vec("gap_b",      1,  0,  0,  16'h0005, 16'h0005, 0, 0, 16'h0005, 0, 0);
    vec("gap_c",      1,  0,  1,  16'h0005, 16'h000A, 1, 0, 16'h000A, 1, 0);
    vec("gap_d",      1,  0,  0,  16'h0005, 16'h000A, 0, 0, 16'h000A, 0, 0);
    vec("to30",       1,  0,  1,  16'h0014, 16'h001E, 1, 0, 16'h001E, 1, 0);
    vec("clr_empty",  1,  1,  0,  16'h0009, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("clr_seed7",  1,  1,  1,  16'h0007, 16'h0007, 1, 0, 16'h0007, 1, 0);
    vec("preload",    1,  1,  1,  16'hFFF0, 16'hFFF0, 1, 0, 16'hFFF0, 1, 0);
    vec("carry",      1,  0,  1,  16'h0020, 16'h0010, 1, 1, 16'hFFFF, 1, 1);
    vec("after_ovf",  1,  0,  1,  16'h0003, 16'h0013, 1, 1, 16'hFFFF, 1, 1);
    vec("hold_ovf",   1,  0,  0,  16'h0003, 16'h0013, 0, 1, 16'hFFFF, 0, 1);
    vec("clr_ovf",    1,  1,  1,  16'h0007, 16'h0007, 1, 0, 16'h0007, 1, 0);
    vec("add_zero",   1,  0,  1,  16'h0000, 16'h0007, 1, 0, 16'h0007, 1, 0);
    vec("exact_max",  1,  0,  1,  16'hFFF8, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
    vec("max_plus1",  1,  0,  1,  16'h0001, 16'h0000, 1, 1, 16'hFFFF, 1, 1);
    vec("sat_zero",   1,  0,  1,  16'h0000, 16'h0000, 1, 1, 16'hFFFF, 1, 1);
    vec("rst_prio",   0,  1,  1,  16'h0009, 16'h0000, 0, 0, 16'h0000, 0, 0);
    vec("resume",     1,  0,  1,  16'h0009, 16'h0009, 1, 0, 16'h0009, 1, 0);
    vec("resume_idl", 1,  0,  0,  16'h0009, 16'h0009, 0, 0, 16'h0009, 0, 0);

    // Let the monitor drain the last entries, bounded by a cycle budget.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscmp++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule : tb_integrator
